lfsr_4_checker: RTL and testbench
=================================

Name: lfsr_4_checker

Overview:
- Receive-side PRBS checker for the 4-bit LFSR stream, polynomial X^4 + X^3 + 1. Next word is {w[2:0], w[3]^w[2]}; sequence period is 15.
- Self-synchronises on the incoming parallel words and declares lock after enough consecutive correct words.
- Once locked, flags and counts mismatches against its own free-running prediction.
- Sits at the far end of a link or loopback path, opposite the 4-bit LFSR generator.

Parameters:
- LOCK_CNT, 4: consecutive correct words in VERIFY needed to enter LOCKED. Legal range 1..15.
- UNLOCK_CNT, 3: consecutive mismatched words in LOCKED needed to drop back to SEARCH. Legal range 1..15.
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  clock, active on rising edge
- rst_n  input  1  asynchronous reset, active low
- data_in  input  4  received LFSR word
- data_vld  input  1  data_in valid this cycle
- clr_cnt  input  1  synchronous clear of err_cnt
- locked  output  1  checker is in LOCKED state
- err_pulse  output  1  one-cycle flag: last valid word mismatched while LOCKED
- err_cnt  output  CNT_W  saturating error count
- zero_det  output  1  one-cycle flag: an all-zero valid word was received

Behaviour:
- Reset (async, rst_n low):
  - state = SEARCH; locked = 0, err_pulse = 0, err_cnt = 0, zero_det = 0.
  - Internal expected = 4'b0001; match/miss counters = 0.
- All outputs are registered. Each is updated on the edge that samples a valid word, i.e. 1-cycle latency.
- data_vld = 0: state, expected and counters hold; err_pulse and zero_det go 0.
- nxt(x) = {x[2:0], x[3]^x[2]}.
- SEARCH:
  - On a valid nonzero word: expected = nxt(data_in), match_cnt = 0, go to VERIFY.
  - On a zero word: stay in SEARCH.
- VERIFY:
  - data_in == expected: match_cnt+1 and expected = nxt(data_in). When match_cnt reaches LOCK_CNT, go to LOCKED and set locked = 1 on that edge.
  - Mismatch on a nonzero word: re-seed with expected = nxt(data_in), match_cnt = 0, stay in VERIFY.
  - Zero word: go to SEARCH.
- LOCKED:
  - Match: expected = nxt(data_in), miss_cnt = 0.
  - Mismatch: expected = nxt(expected), so a corrupted word does not corrupt the prediction. Also err_pulse = 1, err_cnt increments, miss_cnt+1.
  - When miss_cnt reaches UNLOCK_CNT: go to SEARCH, locked = 0, miss_cnt = 0. The error on that word is still counted.
- zero_det = 1 for any valid all-zero word, in every state. In LOCKED a zero word is also a mismatch.
- err_cnt:
  - Saturates at all-ones; it never wraps.
  - Changes only in LOCKED. Clearing is independent of state.
  - clr_cnt has priority over an increment in the same cycle: the result is 0 and the concurrent error is dropped. err_pulse still asserts for that error.
- No errors are counted in SEARCH or VERIFY.
- Reset mid-operation returns immediately to the reset values; no partial lock is retained.

Optional Feature:
- Macro: LFSR_4_CHECKER_BIT_ERR_EN.
- Defined: err_cnt increments by popcount(data_in ^ expected), range 1..4, per mismatched LOCKED word. The result saturates at all-ones. Also adds output bit_err[2:0], registered with err_pulse, carrying that popcount (0 when no error).
- Undefined: err_cnt increments by exactly 1 per mismatched word; no bit_err port.

Test Plan:
- Lock from reset: apply the generator sequence 0001,0010,0100,1001,0011,0110,... with data_vld = 1 every cycle -> locked rises on the edge sampling the 5th word (0011). err_cnt stays 0 over 100 words.
- Mid-sequence start with gaps: start at 1101 and toggle data_vld low every other cycle -> lock after 5 valid words, no errors. Outputs hold during the gaps.
- Single corruption: while locked, replace 0101 with 0111 -> one err_pulse, err_cnt = 1, locked stays 1. The next word, 1011, is accepted with no further error.
- Loss of lock: while locked, drive 3 consecutive wrong words (0000, 1111, 1111) -> err_cnt +3, locked falls after the 3rd. zero_det pulses on the 0000 word. The checker then relocks on the resumed correct sequence.
- Saturation and clear: force err_cnt near 16'hFFFF via repeated errors interleaved with relock -> the counter holds at FFFF. clr_cnt asserted together with an error -> err_cnt = 0 and err_pulse = 1.
- With LFSR_4_CHECKER_BIT_ERR_EN: expected 1010, received 0101 -> bit_err = 4, err_cnt +4.

Source files
------------

// File: rtl/lfsr_4_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_4_checker
// Purpose  : Receive-side PRBS checker for the 4-bit LFSR stream generated by
//            the polynomial X^4 + X^3 + 1 (next = {w[2:0], w[3]^w[2]},
//            period 15). The checker self-synchronises on incoming words,
//            declares lock after LOCK_CNT consecutive correct words, then
//            flags and counts mismatches against a free-running prediction.
//            It drops lock after UNLOCK_CNT consecutive mismatches.
//
// Ports    : clk        in   rising-edge clock
//            rst_n      in   asynchronous reset, active low
//            data_in    in   [3:0] received LFSR word
//            data_vld   in   data_in is valid this cycle
//            clr_cnt    in   synchronous clear of err_cnt (wins over increment)
//            locked     out  checker is in LOCKED state
//            err_pulse  out  one-cycle flag: last valid word mismatched while
//                            LOCKED
//            err_cnt    out  [CNT_W-1:0] saturating error count
//            zero_det   out  one-cycle flag: all-zero valid word received
//            bit_err    out  [2:0] bit errors in the flagged word
//                            (only with LFSR_4_CHECKER_BIT_ERR_EN)
//
// Build option : LFSR_4_CHECKER_BIT_ERR_EN
//            Defined   -> err_cnt advances by the number of differing bits
//                         (1..4) per mismatched word, and bit_err is present.
//            Undefined -> err_cnt advances by one per mismatched word.
//
// Revision : 1.0  initial release
// ============================================================================

module lfsr_4_checker #(
   parameter int LOCK_CNT   = 4,   // 1..15
   parameter int UNLOCK_CNT = 3,   // 1..15
   parameter int CNT_W      = 16   // >= 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       data_in,
   input  logic             data_vld,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic             zero_det
`ifdef LFSR_4_CHECKER_BIT_ERR_EN
   ,
   output logic [2:0]       bit_err
`endif
);

   // ------------------------------------------------------------------------
   // Constants and types
   // ------------------------------------------------------------------------
   localparam logic [3:0] c_LOCK_CNT   = 4'(LOCK_CNT);
   localparam logic [3:0] c_UNLOCK_CNT = 4'(UNLOCK_CNT);
   localparam logic [3:0] c_SEED       = 4'b0001;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [3:0] lfsr_nxt(input logic [3:0] x);
      return {x[2:0], x[3] ^ x[2]};
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t           r_state;
   logic [3:0]       r_expected;
   logic [3:0]       r_match_cnt;
   logic [3:0]       r_miss_cnt;

   // ------------------------------------------------------------------------
   // Combinational next-state
   // ------------------------------------------------------------------------
   state_t           w_state_nxt;
   logic [3:0]       w_expected_nxt;
   logic [3:0]       w_match_cnt_nxt;
   logic [3:0]       w_miss_cnt_nxt;
   logic [CNT_W-1:0] w_err_cnt_nxt;
   logic             w_err_hit;
   logic             w_zero_hit;
   logic             w_is_zero;
   logic             w_is_match;
   logic [3:0]       w_match_inc;
   logic [3:0]       w_miss_inc;
   logic [CNT_W:0]   w_err_inc;
   logic [CNT_W:0]   w_err_sum;

`ifdef LFSR_4_CHECKER_BIT_ERR_EN
   logic [3:0]       w_diff;
   logic [2:0]       w_popcnt;

   assign w_diff   = data_in ^ r_expected;
   assign w_popcnt = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);
   assign w_err_inc = (CNT_W + 1)'(w_popcnt);
`else
   assign w_err_inc = (CNT_W + 1)'(1);
`endif

   assign w_is_zero   = (data_in == 4'd0);
   assign w_is_match  = (data_in == r_expected);
   assign w_match_inc = r_match_cnt + 4'd1;
   assign w_miss_inc  = r_miss_cnt + 4'd1;
   // One extra bit catches overflow so the counter can pin at all-ones.
   assign w_err_sum   = {1'b0, err_cnt} + w_err_inc;

   always_comb begin
      w_state_nxt     = r_state;
      w_expected_nxt  = r_expected;
      w_match_cnt_nxt = r_match_cnt;
      w_miss_cnt_nxt  = r_miss_cnt;
      w_err_hit       = 1'b0;
      w_zero_hit      = data_vld & w_is_zero;

      if (data_vld) begin
         case (r_state)
            SEARCH: begin
               // Any nonzero word is a valid point on the sequence; use it
               // as the seed for the prediction.
               if (!w_is_zero) begin
                  w_expected_nxt  = lfsr_nxt(data_in);
                  w_match_cnt_nxt = 4'd0;
                  w_state_nxt     = VERIFY;
               end
            end

            VERIFY: begin
               if (w_is_match) begin
                  w_expected_nxt = lfsr_nxt(data_in);
                  if (w_match_inc == c_LOCK_CNT) begin
                     w_state_nxt     = LOCKED;
                     w_match_cnt_nxt = 4'd0;
                     w_miss_cnt_nxt  = 4'd0;
                  end else begin
                     w_match_cnt_nxt = w_match_inc;
                  end
               end else if (!w_is_zero) begin
                  // Wrong guess at the sequence phase: re-seed from this word.
                  w_expected_nxt  = lfsr_nxt(data_in);
                  w_match_cnt_nxt = 4'd0;
               end else begin
                  w_state_nxt     = SEARCH;
                  w_match_cnt_nxt = 4'd0;
               end
            end

            LOCKED: begin
               if (w_is_match) begin
                  w_expected_nxt = lfsr_nxt(data_in);
                  w_miss_cnt_nxt = 4'd0;
               end else begin
                  // Advance from our own prediction so a corrupted word does
                  // not poison the following comparisons.
                  w_expected_nxt = lfsr_nxt(r_expected);
                  w_err_hit      = 1'b1;
                  if (w_miss_inc == c_UNLOCK_CNT) begin
                     w_state_nxt    = SEARCH;
                     w_miss_cnt_nxt = 4'd0;
                  end else begin
                     w_miss_cnt_nxt = w_miss_inc;
                  end
               end
            end

            default: begin
               w_state_nxt     = SEARCH;
               w_match_cnt_nxt = 4'd0;
               w_miss_cnt_nxt  = 4'd0;
            end
         endcase
      end

      // Clear takes priority; an error landing in the same cycle is dropped.
      w_err_cnt_nxt = err_cnt;
      if (clr_cnt) begin
         w_err_cnt_nxt = '0;
      end else if (w_err_hit) begin
         if (w_err_sum[CNT_W]) begin
            w_err_cnt_nxt = '1;
         end else begin
            w_err_cnt_nxt = w_err_sum[CNT_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SEARCH;
         r_expected  <= c_SEED;
         r_match_cnt <= 4'd0;
         r_miss_cnt  <= 4'd0;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         err_cnt     <= '0;
         zero_det    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_expected  <= w_expected_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_miss_cnt  <= w_miss_cnt_nxt;
         locked      <= (w_state_nxt == LOCKED);
         err_pulse   <= w_err_hit;
         err_cnt     <= w_err_cnt_nxt;
         zero_det    <= w_zero_hit;
      end
   end

`ifdef LFSR_4_CHECKER_BIT_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_err <= 3'd0;
      end else begin
         bit_err <= w_err_hit ? w_popcnt : 3'd0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_4_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_4_checker
// Purpose  : Directed scoreboard bench for lfsr_4_checker. Stimulus pushes
//            hand-derived expected outputs into a queue; a monitor pops one
//            entry per applied cycle just after the sampling edge and compares.
//            A second instance with a 4-bit counter shares the stimulus and
//            exercises saturation.
// Revision : 1.0  initial release
// ============================================================================

module tb_lfsr_4_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  data_in;
   logic        data_vld;
   logic        clr_cnt;
   logic        locked,   locked_s;
   logic        err_pulse, err_pulse_s;
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt_s;
   logic        zero_det, zero_det_s;
`ifdef LFSR_4_CHECKER_BIT_ERR_EN
   logic [2:0]  bit_err, bit_err_s;
`endif

   always #5 clk = ~clk;

   lfsr_4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
      .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .zero_det(zero_det)
`ifdef LFSR_4_CHECKER_BIT_ERR_EN
      , .bit_err(bit_err)
`endif
   );

   lfsr_4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
      .clr_cnt(clr_cnt), .locked(locked_s), .err_pulse(err_pulse_s),
      .err_cnt(err_cnt_s), .zero_det(zero_det_s)
`ifdef LFSR_4_CHECKER_BIT_ERR_EN
      , .bit_err(bit_err_s)
`endif
   );

   typedef struct {
      logic lk;
      logic ep;
      int   cnt;
      logic zd;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   logic [3:0] g;

   function automatic logic [3:0] nxt(input logic [3:0] x);
      return {x[2:0], x[3] ^ x[2]};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue its expected registered response.
   task automatic apply(input logic [3:0] d, input logic v, input logic c,
                        input logic el, input logic ep, input int ec,
                        input logic ez);
      exp_t e;
      @(negedge clk);
      data_in  = d;
      data_vld = v;
      clr_cnt  = c;
      e.lk = el; e.ep = ep; e.cnt = ec; e.zd = ez;
      exp_q.push_back(e);
   endtask

   // Drive reset and check the asynchronous clear before any clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n    = 1'b0;
      data_vld = 1'b0;
      clr_cnt  = 1'b0;
      data_in  = 4'd0;
      #1;
      check({tag, "_locked"},    int'(locked),    0);
      check({tag, "_err_pulse"}, int'(err_pulse), 0);
      check({tag, "_err_cnt"},   int'(err_cnt),   0);
      check({tag, "_zero_det"},  int'(zero_det),  0);
      check({tag, "_sat_cnt"},   int'(err_cnt_s), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: one expectation per applied cycle, sampled after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",    int'(locked),    int'(e.lk));
            check("err_pulse", int'(err_pulse), int'(e.ep));
            check("err_cnt",   int'(err_cnt),   e.cnt);
            check("zero_det",  int'(zero_det),  int'(e.zd));
            check("sat_cnt",   int'(err_cnt_s), (e.cnt > 15) ? 15 : e.cnt);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] w;
      rst_n    = 1'b0;
      data_in  = 4'd0;
      data_vld = 1'b0;
      clr_cnt  = 1'b0;

      // Reset state
      do_reset("por");

      // Lock from reset: locked rises on the 5th word (0011), no errors.
      g = 4'b0001;
      for (int i = 0; i < 100; i++) begin
         apply(g, 1'b1, 1'b0, (i >= 4), 1'b0, 0, 1'b0);
         g = nxt(g);
      end

      // Single corruption: 0101 replaced with 0111, then 1011 accepted.
      while (g != 4'b0101) begin
         apply(g, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
         g = nxt(g);
      end
      apply(4'b0111, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      g = nxt(g);
      apply(4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
      g = nxt(g);
      for (int i = 0; i < 4; i++) begin   // 0111,1111,1110,1100
         apply(g, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
         g = nxt(g);
      end

      // Loss of lock: expected 1000,0001,0010 replaced by 0000,1111,1111.
      apply(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1); g = nxt(g);
      apply(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0); g = nxt(g);
      apply(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0); g = nxt(g);
      // Relock on resumed sequence from 0100.
      for (int i = 0; i < 6; i++) begin
         apply(g, 1'b1, 1'b0, (i >= 4), 1'b0, 4, 1'b0);
         g = nxt(g);
      end

      // Asynchronous reset mid-operation clears the nonzero counter at once.
      do_reset("mid");

      // Zero in SEARCH stays; zero in VERIFY returns to SEARCH.
      apply(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      apply(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      apply(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b1101, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      apply(4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);

      // Mismatch in VERIFY re-seeds and restarts the match count.
      do_reset("rs1");
      apply(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply(4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);

      // Mid-sequence start at 1101 with gaps; outputs hold, zero data with
      // data_vld low is not a zero detection.
      do_reset("rs2");
      g = 4'b1101;
      for (int i = 0; i < 7; i++) begin
         apply(g, 1'b1, 1'b0, (i >= 4), 1'b0, 0, 1'b0);
         apply(4'b0000, 1'b0, 1'b0, (i >= 4), 1'b0, 0, 1'b0);
         g = nxt(g);
      end

      // Saturation: alternate error / correct word so lock is kept.
      for (int k = 0; k < 18; k++) begin
         w = ~g;
         apply(w, 1'b1, 1'b0, 1'b1, 1'b1, k + 1, (w == 4'd0));
         g = nxt(g);
         apply(g, 1'b1, 1'b0, 1'b1, 1'b0, k + 1, 1'b0);
         g = nxt(g);
      end

      // Clear together with an error: count 0, pulse still asserts.
      w = ~g;
      apply(w, 1'b1, 1'b1, 1'b1, 1'b1, 0, (w == 4'd0));
      g = nxt(g);
      apply(g, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      g = nxt(g);
      w = ~g;
      apply(w, 1'b1, 1'b0, 1'b1, 1'b1, 1, (w == 4'd0));
      g = nxt(g);
      apply(g, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);

      @(negedge clk);
      data_vld = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
